// File: rtl/ieee754_pkg.sv
// Shared constants and state encoding for the IEEE-754 single-precision normalizer.
package ieee754_pkg;

  localparam int BIAS       = 127;
  localparam int EXP_MAX    = 255;
  localparam int HIDDEN_BIT = 23;
  localparam int FRAC_W     = 23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/ieee754_round_pack.sv
// Round-to-nearest-even on a normalized 24-bit mantissa, then pack with
// overflow-to-infinity and flush-to-zero of underflowing exponents.
module ieee754_round_pack
  import ieee754_pkg::*;
(
  input  logic                sign,
  input  logic [HIDDEN_BIT:0] mant_in,
  input  logic                round_bit,
  input  logic                sticky,
  input  logic signed [31:0]  exp_in,
  output logic [31:0]         float_out
);

  logic                  inc;
  logic [HIDDEN_BIT+1:0] sum;
  logic [FRAC_W-1:0]     frac;
  logic signed [31:0]    exp_adj;

  always_comb begin
    inc = round_bit & (sticky | mant_in[0]);
    sum = {1'b0, mant_in} + {{(HIDDEN_BIT+1){1'b0}}, inc};
    // A carry out of the hidden bit renormalizes by one place.
    if (sum[HIDDEN_BIT+1]) begin
      frac    = sum[FRAC_W:1];
      exp_adj = exp_in + 32'sd1;
    end else begin
      frac    = sum[FRAC_W-1:0];
      exp_adj = exp_in;
    end

    if (exp_adj >= EXP_MAX) begin
      float_out = {sign, 8'hFF, {FRAC_W{1'b0}}};
    end else if (exp_adj <= 0) begin
      float_out = {sign, 31'b0};
    end else begin
      float_out = {sign, exp_adj[7:0], frac};
    end
  end

endmodule

// File: rtl/ieee754_normalize.sv
// Iterative normalizer: one mantissa shift per cycle until the leading one sits
// on the hidden bit, then a single round/pack cycle and a held result.
module ieee754_normalize
  import ieee754_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign,
  input  logic [31:0] fraction,
  input  logic [31:0] exponent,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] float
);

  state_e             state_q, state_d;
  logic [31:0]        m_q, m_d;
  logic signed [31:0] e_q, e_d;
  logic               s_q, s_d;
  logic               r_q, r_d;
  logic               st_q, st_d;
  logic [31:0]        float_q, float_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        packed_float;

  ieee754_round_pack u_round_pack (
    .sign      (s_q),
    .mant_in   (m_q[HIDDEN_BIT:0]),
    .round_bit (r_q),
    .sticky    (st_q),
    .exp_in    (e_q),
    .float_out (packed_float)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      m_q         <= '0;
      e_q         <= '0;
      s_q         <= 1'b0;
      r_q         <= 1'b0;
      st_q        <= 1'b0;
      float_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      e_q         <= e_d;
      s_q         <= s_d;
      r_q         <= r_d;
      st_q        <= st_d;
      float_q     <= float_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    e_d         = e_q;
    s_d         = s_q;
    r_d         = r_q;
    st_d        = st_q;
    float_d     = float_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d     = fraction;
          e_d     = exponent;
          s_d     = sign;
          r_d     = 1'b0;
          st_d    = 1'b0;
          state_d = NORM;
        end
      end
      NORM: begin
        if (m_q == '0) begin
          float_d = {s_q, 31'b0};
          state_d = DONE;
        end else if (|m_q[31:HIDDEN_BIT+1]) begin
          // Bits falling off the bottom feed the round and sticky bits.
          st_d = st_q | r_q;
          r_d  = m_q[0];
          m_d  = m_q >> 1;
          e_d  = e_q + 32'sd1;
        end else if (!m_q[HIDDEN_BIT]) begin
          m_d = m_q << 1;
          e_d = e_q - 32'sd1;
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        float_d = packed_float;
        state_d = DONE;
      end
      DONE: begin
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign float     = float_q;

endmodule

// File: tb/tb_ieee754_normalize.sv
// Randomized and directed bench for ieee754_normalize against a value-level model.
module tb_ieee754_normalize;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign = 1'b0;
  logic [31:0] fraction = '0;
  logic [31:0] exponent = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] float;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cap_cyc = 0;
  int exp_lat = 0;
  bit exp_busy = 0;
  logic [31:0] exp_float = '0;

  ieee754_normalize dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign      (sign),
    .fraction  (fraction),
    .exponent  (exponent),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .float     (float)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Value-level model: locate the leading one, shift it onto bit 23 in one go,
  // round to nearest even, then pack.
  function automatic void model(input logic s, input logic [31:0] f,
                                input logic [31:0] e, output logic [31:0] res,
                                output int lat);
    int p, k;
    longint ex, mant;
    bit r, st;
    if (f == 0) begin
      res = {s, 31'b0};
      lat = 2;
      return;
    end
    p = 31;
    while (!f[p]) p--;
    ex = longint'($signed(e));
    r = 0;
    st = 0;
    if (p > 23) begin
      k = p - 23;
      mant = longint'(f >> k);
      r = f[k-1];
      if (k >= 2) st = ((f & ((32'h1 << (k - 1)) - 1)) != 0);
      ex = ex + k;
    end else begin
      k = 23 - p;
      mant = longint'(f) << k;
      ex = ex - k;
    end
    lat = k + 3;
    if (r && (st || mant[0])) mant = mant + 1;
    if (mant >= (64'sd1 <<< 24)) begin
      mant = mant >>> 1;
      ex = ex + 1;
    end
    if (ex >= 255)     res = {s, 8'hFF, 23'b0};
    else if (ex <= 0)  res = {s, 31'b0};
    else               res = {s, ex[7:0], mant[22:0]};
  endfunction

  // Every-cycle comparison of handshake and result against the model.
  always @(negedge clk) begin
    bit exp_v;
    if (rst_n) begin
      exp_v = exp_busy && ((cyc - cap_cyc) >= exp_lat);
      checks++;
      if (out_valid !== exp_v) begin
        failures++;
        $display("FAIL out_valid cyc=%0d got=%b want=%b", cyc, out_valid, exp_v);
      end
      checks++;
      if (in_ready !== !exp_busy) begin
        failures++;
        $display("FAIL in_ready cyc=%0d got=%b want=%b", cyc, in_ready, !exp_busy);
      end
      if (exp_v) begin
        checks++;
        if (float !== exp_float) begin
          failures++;
          $display("FAIL float cyc=%0d got=%h want=%h", cyc, float, exp_float);
        end
      end
    end
  end

  task automatic check_idle_after_reset(input string name);
    checks++;
    if (float !== 32'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s got float=%h out_valid=%b in_ready=%b want float=00000000 out_valid=0 in_ready=1",
               name, float, out_valid, in_ready);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    exp_busy = 0;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_after_reset("reset_state");
  endtask

  task automatic run_op(input logic s, input logic [31:0] f, input logic [31:0] e,
                        input int hold, output logic [31:0] got, output int lat_got);
    logic [31:0] mf;
    int ml, n, h;
    bit seen, done;
    model(s, f, e, mf, ml);
    got = '0;
    lat_got = -1;
    h = hold;
    seen = 0;
    done = 0;
    @(negedge clk);
    exp_float = mf;
    exp_lat = ml;
    sign = s;
    fraction = f;
    exponent = e;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    exp_busy = 1;
    cap_cyc = cyc;
    in_valid = 1'b0;
    n = 0;
    while (!done && n < ml + hold + 20) begin
      @(negedge clk);
      n++;
      in_valid = 1'($urandom_range(0, 1));
      fraction = $urandom;
      exponent = $urandom;
      if (out_valid) begin
        if (!seen) begin
          seen = 1;
          lat_got = cyc - cap_cyc;
          got = float;
        end
        if (h > 0) begin
          h--;
          out_ready = 1'b0;
        end else begin
          out_ready = 1'b1;
          @(posedge clk);
          #1;
          exp_busy = 0;
          out_ready = 1'b0;
          in_valid = 1'b0;
          done = 1;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL timeout f=%h e=%h got no release want release within %0d cycles", f, e, ml + hold + 20);
      do_reset();
    end
  endtask

  logic        dv_s   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] dv_f   [7] = '{32'h00800000, 32'h01800003, 32'h01800001, 32'h00000001,
                              32'h01000000, 32'h00800000, 32'h00000000};
  logic [31:0] dv_e   [7] = '{32'd127, 32'd127, 32'd127, 32'd150, 32'd254,
                              32'hFFFFFFFB, 32'd100};
  int          dv_h   [7] = '{0, 0, 0, 0, 0, 0, 5};
  logic [31:0] dv_res [7] = '{32'h3F800000, 32'h40400002, 32'h40400000, 32'h3F800000,
                              32'hFF800000, 32'h00000000, 32'h80000000};
  int          dv_lat [7] = '{3, 4, 4, 26, 4, 3, 2};

  initial begin
    logic [31:0] got, mres;
    int lat_got, mlat;

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_after_reset("reset_state");

    for (int i = 0; i < 7; i++) begin
      model(dv_s[i], dv_f[i], dv_e[i], mres, mlat);
      checks++;
      if (mres !== dv_res[i] || mlat != dv_lat[i]) begin
        failures++;
        $display("FAIL model_vec%0d got=%h/%0d want=%h/%0d", i, mres, mlat, dv_res[i], dv_lat[i]);
      end
      run_op(dv_s[i], dv_f[i], dv_e[i], dv_h[i], got, lat_got);
      checks++;
      if (got !== dv_res[i]) begin
        failures++;
        $display("FAIL vec%0d_float got=%h want=%h", i, got, dv_res[i]);
      end
      checks++;
      if (lat_got != dv_lat[i]) begin
        failures++;
        $display("FAIL vec%0d_latency got=%0d want=%0d", i, lat_got, dv_lat[i]);
      end
    end

    // Abort a long left-shift operation mid-normalization.
    @(negedge clk);
    model(1'b0, 32'h1, 32'd150, exp_float, exp_lat);
    sign = 1'b0;
    fraction = 32'h1;
    exponent = 32'd150;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    exp_busy = 1;
    cap_cyc = cyc;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    do_reset();
    repeat (30) @(negedge clk);
    run_op(1'b0, 32'h01800003, 32'd127, 0, got, lat_got);
    checks++;
    if (got !== 32'h40400002) begin
      failures++;
      $display("FAIL after_abort_float got=%h want=40400002", got);
    end

    for (int i = 0; i < 250; i++) begin
      logic [31:0] f, e;
      logic s;
      s = 1'($urandom_range(0, 1));
      f = (($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 31)));
      e = 32'($urandom_range(0, 500)) - 32'd200;
      run_op(s, f, e, int'($urandom_range(0, 3)), got, lat_got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
